// File: rtl/sseg_pkg.sv
// sseg_pkg: shared types, segment encodings and bus address for the seven-segment display controller
package sseg_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
    localparam logic [31:0] SSEG_DISP_ADDR = 32'h1100C00C;
    localparam logic [7:0] SEG_0 = 8'hC0, SEG_1 = 8'hF9, SEG_2 = 8'hA4, SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99, SEG_5 = 8'h92, SEG_6 = 8'h82, SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80, SEG_9 = 8'h90, SEG_A = 8'h88, SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6, SEG_D = 8'hA1, SEG_E = 8'h86, SEG_F = 8'h8E;
    localparam logic [7:0] SEG_DASH = 8'hBF, SEG_BLANK = 8'hFF;
    // active-low {dp,g..a} pattern for one nibble; dp stays off
    function automatic logic [7:0] seg_encode(input logic [3:0] n);
        case (n)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction
endpackage

// File: rtl/iobus_sseg_display_if.sv
// iobus_sseg_display_if: MCU I/O bus write path and status read-back for the display block
interface iobus_sseg_display_if;
    logic [31:0] iobus_addr;
    logic [31:0] iobus_out;
    logic        iobus_wr;
    logic [31:0] rd_data;
    modport master (output iobus_addr, iobus_out, iobus_wr, input rd_data);
    modport slave  (input iobus_addr, iobus_out, iobus_wr, output rd_data);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-bit double-dabble converter, one shift per clock, restartable
module bin2bcd_seq
    import sseg_pkg::*;
(
    input  logic        clk,
    input  logic        RST,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);
    conv_state_t r_state, w_next;
    logic [35:0] r_sr, w_adj;
    logic [3:0]  r_cnt;
    // add 3 to every BCD nibble >= 5 ahead of the next shift
    always_comb begin
        w_adj = r_sr;
        for (int k = 0; k < 5; k++)
            if (r_sr[16+4*k +: 4] >= 4'd5) w_adj[16+4*k +: 4] = r_sr[16+4*k +: 4] + 4'd3;
    end
    // next state and status; a start always (re)enters SHIFT
    always_comb begin
        w_next = start ? SHIFT : (r_state == SHIFT) ? ((r_cnt == 4'd15) ? DONE : SHIFT) : IDLE;
        busy   = r_state != IDLE;
        done   = r_state == DONE;
        bcd    = r_sr[35:16];
    end
    // state, shift register and iteration counter
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (start) begin
                r_sr  <= {20'd0, bin};
                r_cnt <= '0;
            end else if (r_state == SHIFT) begin
                r_sr  <= {w_adj[34:0], 1'b0};
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/iobus_sseg_display.sv
// iobus_sseg_display: memory-mapped 4-digit seven-segment controller with hex/decimal modes and digit scan
module iobus_sseg_display
    import sseg_pkg::*;
#(
    parameter int          SCAN_DIV = 50000,
    parameter logic [31:0] ADDR     = SSEG_DISP_ADDR
)(
    input  logic                 clk,
    input  logic                 RST,
    iobus_sseg_display_if.slave  bus,
    output logic [7:0]           segs,
    output logic [3:0]           an
);
    localparam int PW = $clog2(SCAN_DIV);
    logic            w_wr, w_hex, w_busy, w_done;
    logic [19:0]     w_bcd;
    logic [3:0][7:0] w_dec_seg, r_dig;
    logic            r_hex_mode, r_pend;
    logic [PW-1:0]   r_presc;
    logic [1:0]      r_idx;
    logic [7:0]      r_segs;
    logic [3:0]      r_an;
    assign w_wr        = bus.iobus_wr && bus.iobus_addr == ADDR;
    assign w_hex       = bus.iobus_out[16];
    assign bus.rd_data = {30'd0, r_hex_mode, w_busy && r_pend};
    assign segs        = r_segs;
    assign an          = r_an;
    bin2bcd_seq u_conv (
        .clk   (clk),
        .RST   (RST),
        .start (w_wr && !w_hex),
        .bin   (bus.iobus_out[15:0]),
        .busy  (w_busy),
        .done  (w_done),
        .bcd   (w_bcd)
    );
    // decimal digit patterns with leading-zero blanking and >9999 dash override
    always_comb begin
        w_dec_seg = '0;
        for (int k = 0; k < 4; k++) w_dec_seg[k] = seg_encode(w_bcd[4*k +: 4]);
        if (w_bcd[15:12] == 4'd0) w_dec_seg[3] = SEG_BLANK;
        if (w_bcd[15:8] == 8'd0) w_dec_seg[2] = SEG_BLANK;
        if (w_bcd[15:4] == 12'd0) w_dec_seg[1] = SEG_BLANK;
        if (w_bcd[19:16] != 4'd0) w_dec_seg = {4{SEG_DASH}};
    end
    // commit: hex immediately on write, decimal only when the latest requested conversion finishes
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_hex_mode <= 1'b0;
            r_pend     <= 1'b0;
            r_dig      <= {SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_0};
        end else if (w_wr) begin
            r_hex_mode <= w_hex;
            r_pend     <= !w_hex;
            if (w_hex)
                for (int k = 0; k < 4; k++) r_dig[k] <= seg_encode(bus.iobus_out[4*k +: 4]);
        end else if (w_done && r_pend) begin
            r_pend <= 1'b0;
            r_dig  <= w_dec_seg;
        end
    end
    // free-running prescaler; each wrap drives the selected digit and advances the index
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_an    <= 4'hF;
            r_segs  <= SEG_BLANK;
        end else if (r_presc == PW'(SCAN_DIV - 1)) begin
            r_presc <= '0;
            r_idx   <= r_idx + 2'd1;
            r_an    <= ~(4'b1 << r_idx);
            r_segs  <= r_dig[r_idx];
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end
endmodule

// File: tb/tb_iobus_sseg_display.sv
// tb_iobus_sseg_display: directed self-checking bench for the seven-segment display controller
module tb_iobus_sseg_display;
    import sseg_pkg::*;
    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] segs;
    logic [3:0] an;
    logic [7:0] disp [4];
    logic       seen9 = 1'b0;
    int         checks = 0;
    int         errors = 0;
    int         n;
    logic       hb;
    iobus_sseg_display_if bus ();
    iobus_sseg_display #(.SCAN_DIV(4)) dut (
        .clk  (clk),
        .RST  (RST),
        .bus  (bus),
        .segs (segs),
        .an   (an)
    );
    always #5 clk = ~clk;
    // record what each digit position last showed, and whether digit 3 ever displayed a 9
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) if (an == ~(4'b1 << k)) disp[k] = segs;
        if (an == 4'h7 && segs == 8'h90) seen9 = 1'b1;
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.iobus_addr = addr;
        bus.iobus_out  = data;
        bus.iobus_wr   = 1'b1;
        @(negedge clk);
        bus.iobus_wr   = 1'b0;
    endtask
    task automatic busy_len(output int cnt);
        cnt = 0;
        while (bus.rd_data[0] && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
    endtask
    task automatic check_disp(input string tag, input logic [7:0] d3, input logic [7:0] d2,
                              input logic [7:0] d1, input logic [7:0] d0);
        repeat (20) @(negedge clk);
        check($sformatf("%s_d3", tag), disp[3], d3);
        check($sformatf("%s_d2", tag), disp[2], d2);
        check($sformatf("%s_d1", tag), disp[1], d1);
        check($sformatf("%s_d0", tag), disp[0], d0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.iobus_addr = '0;
        bus.iobus_out  = '0;
        bus.iobus_wr   = 1'b0;
        #1 RST = 1'b0;
        repeat (3) @(negedge clk);
        RST = 1'b1;
        repeat (6) @(negedge clk);
        RST = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_segs", segs, 8'hFF);
        check("rst_rd", bus.rd_data, 32'd0);
        @(negedge clk);
        RST = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("prescan_an", an, 4'hF);
        @(posedge clk);
        #1;
        check("scan0_an", an, 4'hE);
        check("scan0_segs", segs, 8'hC0);
        check_disp("rst", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        bus_write(SSEG_DISP_ADDR, 32'h0000_04D2);
        check("dec_rd_busy", bus.rd_data, 32'd1);
        busy_len(n);
        check("dec_busy_len", n, 17);
        check_disp("dec1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);
        bus_write(SSEG_DISP_ADDR, 32'h0000_0007);
        busy_len(n);
        check_disp("dec7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
        bus_write(SSEG_DISP_ADDR, 32'h0000_2710);
        busy_len(n);
        check("ovf_busy_len", n, 17);
        check_disp("ovf", 8'hBF, 8'hBF, 8'hBF, 8'hBF);
        bus_write(SSEG_DISP_ADDR, 32'h0001_BEEF);
        check("hex_rd", bus.rd_data, 32'd2);
        hb = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (bus.rd_data[0]) hb = 1'b1;
        end
        check("hex_busy", hb, 1'b0);
        check_disp("hex", 8'h83, 8'h86, 8'h86, 8'h8E);
        seen9 = 1'b0;
        bus_write(SSEG_DISP_ADDR, 32'h0000_270F);
        repeat (3) @(negedge clk);
        bus_write(SSEG_DISP_ADDR, 32'h0000_002A);
        busy_len(n);
        check("abort_busy_len", n, 17);
        check("abort_rd", bus.rd_data, 32'd0);
        check_disp("abort", 8'hFF, 8'hFF, 8'h99, 8'hA4);
        check("abort_no9999", seen9, 1'b0);
        bus_write(SSEG_DISP_ADDR, 32'h0000_22B8);
        repeat (2) @(negedge clk);
        bus_write(SSEG_DISP_ADDR, 32'h0001_0042);
        check("hexabort_rd", bus.rd_data, 32'd2);
        repeat (20) @(negedge clk);
        check_disp("hexabort", 8'hC0, 8'hC0, 8'h99, 8'hA4);
        bus_write(32'h1100_C008, 32'h0000_1111);
        check("badaddr_rd", bus.rd_data, 32'd2);
        check_disp("badaddr", 8'hC0, 8'hC0, 8'h99, 8'hA4);
        bus_write(SSEG_DISP_ADDR, 32'h0000_162E);
        repeat (5) @(negedge clk);
        RST = 1'b0;
        #1 check("midrst_rd", bus.rd_data, 32'd0);
        @(negedge clk);
        RST = 1'b1;
        check_disp("midrst", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
